irq_servicer: RTL and testbench

CPU-side bus master for the interrupt controller's register interface. It programs the controller's enable register after reset, then services `cpu_irq`. For each request it reads the pending register, dispatches the lowest-numbered pending source as a vector to the host handler, waits for the handler to finish, and writes the acknowledge register. It sits between the interrupt controller's register port and the processor's handler logic.

---
 rtl/irq_servicer.sv | 224 ++++++++++++++++++++++
 tb/tb_irq_servicer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_servicer.sv
// Bus master that programs the interrupt controller's enable register, then services
// cpu interrupts: read pending, dispatch lowest source to the handler, acknowledge, repeat.
module irq_servicer #(
    parameter int                    INTR_WIDTH      = 8,
    parameter int                    ADDR_WIDTH      = 5,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    IRQ_SENSITIVITY = 1,
    parameter int                    IRQ_ACTIVESTATE = 1,
    parameter logic [INTR_WIDTH-1:0] EN_INIT         = 8'hFF,
    parameter int                    TIMEOUT         = 15,
    parameter int                    HOLDOFF         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          irq_in,
    output logic                          m_read,
    output logic                          m_write,
    output logic [ADDR_WIDTH-1:0]         m_address,
    output logic [DATA_WIDTH-1:0]         m_write_data,
    input  logic [DATA_WIDTH-1:0]         m_read_data,
    input  logic                          m_access_complete,
    output logic                          vec_valid,
    output logic [$clog2(INTR_WIDTH)-1:0] vec_id,
    input  logic                          vec_ready,
    input  logic                          svc_done,
    output logic                          bus_err,
    output logic [7:0]                    spurious_cnt
);

    localparam int ID_W  = $clog2(INTR_WIDTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    localparam int HO_W  = $clog2(HOLDOFF + 1) + 1;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_RD_PEND = 3'd2;
    localparam logic [2:0] S_VEC     = 3'd3;
    localparam logic [2:0] S_SVC     = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] ADDR_EN   = ADDR_WIDTH'(5'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ACK  = ADDR_WIDTH'(5'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PEND = ADDR_WIDTH'(5'h08);

    function automatic logic act(input logic x);
        act = (IRQ_ACTIVESTATE != 0) ? x : ~x;
    endfunction

    function automatic logic [ID_W-1:0] lowest_set(input logic [INTR_WIDTH-1:0] v);
        lowest_set = {ID_W{1'b0}};
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = ID_W'(i);
            end
        end
    endfunction

    logic [2:0]            state_r;
    logic                  irq_q_r;
    logic                  irq_seen_r;
    logic [TMO_W-1:0]      tmo_cnt_r;
    logic [HO_W-1:0]       holdoff_r;
    logic                  m_read_r;
    logic                  m_write_r;
    logic [ADDR_WIDTH-1:0] m_address_r;
    logic [DATA_WIDTH-1:0] m_write_data_r;
    logic                  vec_valid_r;
    logic [ID_W-1:0]       vec_id_r;
    logic                  bus_err_r;
    logic [7:0]            spurious_cnt_r;

    logic                  req_s;
    logic                  rd_enter_s;
    logic                  tmo_hit_s;
    logic [INTR_WIDTH-1:0] pend_s;
    logic                  unused_rdata_s;

    assign pend_s         = m_read_data[INTR_WIDTH-1:0];
    assign unused_rdata_s = ^m_read_data;
    assign tmo_hit_s      = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

    // Service request: sticky edge flag, or live level gated by the post-drain holdoff
    always_comb begin
        req_s = 1'b0;
        if (IRQ_SENSITIVITY != 0) begin
            req_s = irq_seen_r;
        end else if (holdoff_r == {HO_W{1'b0}}) begin
            req_s = act(irq_in);
        end else begin
            req_s = 1'b0;
        end
    end

    // Pending-read entry, from IDLE or from a completed acknowledge in the drain loop
    always_comb begin
        rd_enter_s = 1'b0;
        if ((state_r == S_IDLE) && req_s) begin
            rd_enter_s = 1'b1;
        end else if ((state_r == S_ACK) && m_write_r && m_access_complete) begin
            rd_enter_s = 1'b1;
        end else begin
            rd_enter_s = 1'b0;
        end
    end

    // Edge capture; a new edge beats the clear so it is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q_r    <= 1'b0;
            irq_seen_r <= 1'b0;
        end else begin
            irq_q_r <= irq_in;
            if (IRQ_SENSITIVITY == 0) begin
                irq_seen_r <= 1'b0;
            end else if (act(irq_in) && !act(irq_q_r)) begin
                irq_seen_r <= 1'b1;
            end else if (rd_enter_s) begin
                irq_seen_r <= 1'b0;
            end else begin
                irq_seen_r <= irq_seen_r;
            end
        end
    end

    // Sequencer and bus master; each bus state raises its request one cycle after entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_INIT;
            tmo_cnt_r      <= {TMO_W{1'b0}};
            holdoff_r      <= {HO_W{1'b0}};
            m_read_r       <= 1'b0;
            m_write_r      <= 1'b0;
            m_address_r    <= {ADDR_WIDTH{1'b0}};
            m_write_data_r <= {DATA_WIDTH{1'b0}};
            vec_valid_r    <= 1'b0;
            vec_id_r       <= {ID_W{1'b0}};
            bus_err_r      <= 1'b0;
            spurious_cnt_r <= 8'd0;
        end else begin
            bus_err_r <= 1'b0;
            if (holdoff_r != {HO_W{1'b0}}) begin
                holdoff_r <= holdoff_r - {{(HO_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
                S_INIT, S_ACK: begin
                    if (!m_write_r) begin
                        m_write_r   <= 1'b1;
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                        m_address_r <= (state_r == S_INIT) ? ADDR_EN : ADDR_ACK;
                        m_write_data_r <= (state_r == S_INIT) ? DATA_WIDTH'(EN_INIT)
                                        : ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << vec_id_r);
                    end else if (m_access_complete) begin
                        m_write_r <= 1'b0;
                        state_r   <= (state_r == S_INIT) ? S_IDLE : S_RD_PEND;
                    end else if (tmo_hit_s) begin
                        m_write_r <= 1'b0;
                        bus_err_r <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                S_IDLE: begin
                    if (req_s) begin
                        state_r <= S_RD_PEND;
                    end
                end
                S_RD_PEND: begin
                    if (!m_read_r) begin
                        m_read_r    <= 1'b1;
                        m_address_r <= ADDR_PEND;
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                    end else if (m_access_complete) begin
                        m_read_r <= 1'b0;
                        if (pend_s == {INTR_WIDTH{1'b0}}) begin
                            if (spurious_cnt_r != 8'hFF) begin
                                spurious_cnt_r <= spurious_cnt_r + 8'd1;
                            end
                            holdoff_r <= HO_W'(HOLDOFF);
                            state_r   <= S_IDLE;
                        end else begin
                            vec_id_r    <= lowest_set(pend_s);
                            vec_valid_r <= 1'b1;
                            state_r     <= S_VEC;
                        end
                    end else if (tmo_hit_s) begin
                        m_read_r  <= 1'b0;
                        bus_err_r <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                S_VEC: begin
                    if (vec_ready) begin
                        vec_valid_r <= 1'b0;
                        state_r     <= S_SVC;
                    end
                end
                S_SVC: begin
                    if (svc_done) begin
                        state_r <= S_ACK;
                    end
                end
                default: begin
                    m_read_r    <= 1'b0;
                    m_write_r   <= 1'b0;
                    vec_valid_r <= 1'b0;
                    state_r     <= S_INIT;
                end
            endcase
        end
    end

    assign m_read       = m_read_r;
    assign m_write      = m_write_r;
    assign m_address    = m_address_r;
    assign m_write_data = m_write_data_r;
    assign vec_valid    = vec_valid_r;
    assign vec_id       = vec_id_r;
    assign bus_err      = bus_err_r;
    assign spurious_cnt = spurious_cnt_r;

endmodule

// File: tb/tb_irq_servicer.sv
// Bench for irq_servicer: edge-mode instance driven by a drain table plus corner sequences,
// and a level-mode instance for the holdoff window.
module tb_irq_servicer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        irq_in = 1'b0;
    logic        m_read, m_write;
    logic [4:0]  m_address;
    logic [31:0] m_write_data;
    logic [31:0] m_read_data = 32'h0;
    logic        m_access_complete = 1'b0;
    logic        vec_valid;
    logic [2:0]  vec_id;
    logic        vec_ready = 1'b0, svc_done = 1'b0;
    logic        bus_err;
    logic [7:0]  spurious_cnt;

    logic        irq_l = 1'b0;
    logic        m_read_l, m_write_l;
    logic [4:0]  m_address_l;
    logic [31:0] m_write_data_l;
    logic [31:0] rdata_l = 32'h0;
    logic        cpl_l = 1'b0;
    logic        vec_valid_l;
    logic [2:0]  vec_id_l;
    logic        vec_ready_l = 1'b0, svc_done_l = 1'b0;
    logic        bus_err_l;
    logic [7:0]  spurious_cnt_l;

    irq_servicer dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_write_data(m_write_data), .m_read_data(m_read_data),
        .m_access_complete(m_access_complete),
        .vec_valid(vec_valid), .vec_id(vec_id), .vec_ready(vec_ready),
        .svc_done(svc_done), .bus_err(bus_err), .spurious_cnt(spurious_cnt)
    );

    irq_servicer #(.IRQ_SENSITIVITY(0)) dut_l (
        .clk(clk), .reset(reset), .irq_in(irq_l),
        .m_read(m_read_l), .m_write(m_write_l), .m_address(m_address_l),
        .m_write_data(m_write_data_l), .m_read_data(rdata_l),
        .m_access_complete(cpl_l),
        .vec_valid(vec_valid_l), .vec_id(vec_id_l), .vec_ready(vec_ready_l),
        .svc_done(svc_done_l), .bus_err(bus_err_l), .spurious_cnt(spurious_cnt_l)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [7:0]  pend;
        logic [2:0]  id;
        logic [31:0] ack;
        bit          new_irq;
        int          hold;
        bit          edge_svc;
    } vec_t;

    acc_t  exp_q[$];
    acc_t  cur_e;
    int    errors = 0, checks = 0;
    int    cyc = 0, cpl_cyc = 0, acc_cnt = 0, err_pulses = 0, rd_cnt_l = 0;
    bit    resp_en = 1'b1;
    logic [31:0] rd_data_v = 32'h0, rd_data_l = 32'h0;
    logic  prev_req = 1'b0, prev_rd_l = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard pop on each new bus request, then a one-cycle completing responder
    always @(negedge clk) begin
        if (bus_err) err_pulses++;
        if ((m_read || m_write) && !prev_req) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access: got addr 0x%0h wr %0d, expected none", m_address, m_write);
            end else begin
                cur_e = exp_q.pop_front();
                chk("acc_is_write", 32'(m_write), 32'(cur_e.wr));
                chk("acc_addr", 32'(m_address), 32'(cur_e.addr));
                chk("acc_exclusive", 32'(m_read & m_write), 32'd0);
                if (cur_e.wr) chk("acc_wdata", m_write_data, cur_e.data);
            end
        end
        prev_req = m_read || m_write;
        if (m_access_complete) begin
            m_access_complete = 1'b0;
        end else if ((m_read || m_write) && resp_en) begin
            m_access_complete = 1'b1;
            m_read_data = rd_data_v;
            cpl_cyc = cyc;
        end
        if (m_read_l && !prev_rd_l) rd_cnt_l++;
        prev_rd_l = m_read_l;
        if (cpl_l) begin
            cpl_l = 1'b0;
        end else if (m_read_l || m_write_l) begin
            cpl_l = 1'b1;
            rdata_l = rd_data_l;
        end
    end

    task automatic pulse_irq();
        @(negedge clk) irq_in = 1'b1;
        repeat (2) @(negedge clk);
        irq_in = 1'b0;
    endtask

    task automatic wait_vec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vec_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    vec_t tbl[9];
    bit   ok;
    int   spur_model = 0;
    int   a0, n, e0, r0;

    initial begin
        tbl[0] = '{8'h24, 3'd2, 32'h04, 1'b1, 10, 1'b0};
        tbl[1] = '{8'h20, 3'd5, 32'h20, 1'b0, 0,  1'b0};
        tbl[2] = '{8'h00, 3'd0, 32'h00, 1'b0, 0,  1'b0};
        tbl[3] = '{8'h81, 3'd0, 32'h01, 1'b1, 0,  1'b1};
        tbl[4] = '{8'h80, 3'd7, 32'h80, 1'b0, 0,  1'b0};
        tbl[5] = '{8'h00, 3'd0, 32'h00, 1'b0, 0,  1'b0};
        tbl[6] = '{8'h00, 3'd0, 32'h00, 1'b1, 0,  1'b0};
        tbl[7] = '{8'h10, 3'd4, 32'h10, 1'b1, 3,  1'b0};
        tbl[8] = '{8'h00, 3'd0, 32'h00, 1'b0, 0,  1'b0};

        // Reset state, then the enable write
        repeat (3) @(negedge clk);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_read", 32'(m_read), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_spurious", 32'(spurious_cnt), 32'd0);
        exp_q.push_back('{1'b1, 5'h00, 32'h0000_00FF});
        reset = 1'b0;
        @(negedge clk);
        chk("init_req_first_cycle", 32'(m_write), 32'd1);
        repeat (4) @(negedge clk);
        chk("init_no_bus_err", 32'(err_pulses), 32'd0);
        chk("init_queue_empty", 32'(exp_q.size()), 32'd0);

        // Edge-mode drain table
        for (int i = 0; i < 9; i++) begin
            rd_data_v = {24'h0, tbl[i].pend};
            exp_q.push_back('{1'b0, 5'h08, 32'h0});
            if (tbl[i].new_irq) pulse_irq();
            if (tbl[i].pend != 8'h00) begin
                wait_vec(ok);
                chk("vec_seen", 32'(ok), 32'd1);
                chk("vec_latency", 32'(cyc - cpl_cyc), 32'd1);
                chk("vec_id", 32'(vec_id), 32'(tbl[i].id));
                if (tbl[i].hold > 0) begin
                    repeat (tbl[i].hold) @(negedge clk);
                    chk("vec_held_valid", 32'(vec_valid), 32'd1);
                    chk("vec_held_id", 32'(vec_id), 32'(tbl[i].id));
                end
                exp_q.push_back('{1'b1, 5'h04, tbl[i].ack});
                vec_ready = 1'b1;
                @(negedge clk);
                vec_ready = 1'b0;
                chk("vec_dropped", 32'(vec_valid), 32'd0);
                repeat (2) @(negedge clk);
                if (tbl[i].edge_svc) pulse_irq();
                svc_done = 1'b1;
                @(negedge clk);
                svc_done = 1'b0;
            end else begin
                spur_model++;
                repeat (12) @(negedge clk);
                chk("spurious_cnt", 32'(spurious_cnt), 32'(spur_model));
                chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
                chk("idle_no_vec", 32'(vec_valid), 32'd0);
                a0 = acc_cnt;
                repeat (8) @(negedge clk);
                chk("no_extra_read", 32'(acc_cnt), 32'(a0));
            end
        end

        // Pending read never completes: 15 cycles of request, one bus_err pulse
        resp_en = 1'b0;
        rd_data_v = 32'h0;
        e0 = err_pulses;
        exp_q.push_back('{1'b0, 5'h08, 32'h0});
        @(negedge clk) irq_in = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && !m_read; i++) @(negedge clk);
        chk("tmo_read_seen", 32'(m_read), 32'd1);
        irq_in = 1'b0;
        while (m_read && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(n), 32'd15);
        repeat (3) @(negedge clk);
        chk("tmo_err_pulses", 32'(err_pulses - e0), 32'd1);
        chk("tmo_err_low", 32'(bus_err), 32'd0);
        a0 = acc_cnt;
        resp_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("tmo_stays_idle", 32'(acc_cnt), 32'(a0));
        chk("tmo_no_vec", 32'(vec_valid), 32'd0);

        // Reset while the acknowledge write is outstanding
        rd_data_v = 32'h02;
        exp_q.push_back('{1'b0, 5'h08, 32'h0});
        pulse_irq();
        wait_vec(ok);
        chk("rst_ack_vec_id", 32'(vec_id), 32'd1);
        exp_q.push_back('{1'b1, 5'h04, 32'h02});
        resp_en = 1'b0;
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        svc_done = 1'b1;
        @(negedge clk);
        svc_done = 1'b0;
        for (int i = 0; i < 10 && !m_write; i++) @(negedge clk);
        chk("ack_write_seen", 32'(m_write), 32'd1);
        exp_q.push_back('{1'b1, 5'h00, 32'h0000_00FF});
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ack_write_drop", 32'(m_write), 32'd0);
        chk("rst_ack_spurious", 32'(spurious_cnt), 32'd0);
        reset = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        chk("init_reissue", 32'(m_write), 32'd1);
        repeat (4) @(negedge clk);
        chk("reinit_queue_empty", 32'(exp_q.size()), 32'd0);

        // Level mode: irq held 3 cycles past the drain stays inside the holdoff
        r0 = rd_cnt_l;
        rd_data_l = 32'h08;
        @(negedge clk) irq_l = 1'b1;
        for (int i = 0; i < 30 && !vec_valid_l; i++) @(negedge clk);
        chk("lvl_vec_valid", 32'(vec_valid_l), 32'd1);
        chk("lvl_vec_id", 32'(vec_id_l), 32'd3);
        rd_data_l = 32'h0;
        vec_ready_l = 1'b1;
        @(negedge clk);
        vec_ready_l = 1'b0;
        repeat (2) @(negedge clk);
        svc_done_l = 1'b1;
        @(negedge clk);
        svc_done_l = 1'b0;
        for (int i = 0; i < 30 && rd_cnt_l != r0 + 2; i++) @(negedge clk);
        chk("lvl_drain_read", 32'(rd_cnt_l - r0), 32'd2);
        repeat (3) @(negedge clk);
        irq_l = 1'b0;
        repeat (12) @(negedge clk);
        chk("lvl_holdoff_no_read", 32'(rd_cnt_l - r0), 32'd2);
        chk("lvl_spurious", 32'(spurious_cnt_l), 32'd1);
        irq_l = 1'b1;
        for (int i = 0; i < 20 && rd_cnt_l != r0 + 3; i++) @(negedge clk);
        chk("lvl_read_after_holdoff", 32'(rd_cnt_l - r0), 32'd3);
        irq_l = 1'b0;
        repeat (10) @(negedge clk);
        chk("lvl_spurious_2", 32'(spurious_cnt_l), 32'd2);
        chk("lvl_no_bus_err", 32'(bus_err_l), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
